// File: rtl/machine_control_gen.sv
// machine_control_gen: debounced motor/sensor supervisor with per-motor
// degrade, latched fault sources, ack/auto restart (MC_AUTO_RESTART_EN).
//
// Ports: CLK, RST (sync, active-high); MOT_ERR[N_MOT], FAIL_SENSn[N_SENS]
// (active-low), FAULT_ACK in; MOT_ENA[N_MOT], LED_GREEN, LED_RED,
// FAULT_SRC[N_MOT+N_SENS] (motors low, sensors high), STATE[2] out.
module machine_control_gen #(
  parameter int N_MOT       = 5,
  parameter int N_SENS      = 3,
  parameter int DEB_CYC     = 4,
  parameter int START_DLY   = 16,
  parameter int BLINK_HALF  = 25_000_000,
  parameter int RESTART_CYC = 1000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_MOT-1:0]        MOT_ERR,
  input  logic [N_SENS-1:0]       FAIL_SENSn,
  input  logic                    FAULT_ACK,
  output logic [N_MOT-1:0]        MOT_ENA,
  output logic                    LED_GREEN,
  output logic                    LED_RED,
  output logic [N_MOT+N_SENS-1:0] FAULT_SRC,
  output logic [1:0]              STATE
);

  localparam int NCH = N_MOT + N_SENS;
  localparam int DW  = $clog2(DEB_CYC + 1);
  localparam int SW  = $clog2(START_DLY + 1);
  localparam int BW  = $clog2(BLINK_HALF + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYC);
  localparam logic [SW-1:0] IDLE_MAX = SW'(START_DLY);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DEG   = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [NCH-1:0]   raw_q;
  logic             ack_q;
  logic [DW-1:0]    deb_cnt [NCH];
  logic [DW-1:0]    deb_nxt [NCH];
  logic [NCH-1:0]   flg_q, flg_nxt, rise;
  logic [1:0]       st_q, st_nxt;
  logic [NCH-1:0]   src_q, src_nxt;
  logic [SW-1:0]    idle_cnt, idle_nxt;
  logic             in_vld;
  logic [BW-1:0]    blk_cnt, blk_cnt_nxt;
  logic             blk_q, blk_nxt;
  logic [N_MOT-1:0] ena_q, ena_nxt;
  logic             grn_q, grn_nxt;
  logic             red_q, red_nxt;
  logic             any_flg, mot_rise, sens_rise;
  logic             mot_all, exit_ok, rs_hit;

  // Debounce: counter saturates, flag drops on the first clean sample.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      if (!raw_q[i])
        deb_nxt[i] = '0;
      else if (deb_cnt[i] == DEB_MAX)
        deb_nxt[i] = DEB_MAX;
      else
        deb_nxt[i] = deb_cnt[i] + 1'b1;
      flg_nxt[i] = (deb_nxt[i] == DEB_MAX);
    end
  end

  assign rise      = flg_nxt & ~flg_q;
  assign any_flg   = |flg_nxt;
  assign mot_rise  = |rise[N_MOT-1:0];
  assign sens_rise = |rise[NCH-1:N_MOT];

`ifdef MC_AUTO_RESTART_EN
  localparam int RW = $clog2(RESTART_CYC + 1);
  localparam logic [RW-1:0] RS_MAX = RW'(RESTART_CYC);

  logic [RW-1:0] rs_cnt, rs_nxt;

  always_comb begin
    rs_nxt = '0;
    if ((st_q == S_DEG || st_q == S_FAULT) && !any_flg)
      rs_nxt = (rs_cnt == RS_MAX) ? RS_MAX : rs_cnt + 1'b1;
  end

  assign rs_hit = (rs_nxt == RS_MAX);

  always_ff @(posedge CLK) begin
    if (RST)
      rs_cnt <= '0;
    else if (st_nxt == S_DEG || st_nxt == S_FAULT)
      rs_cnt <= rs_nxt;
    else
      rs_cnt <= '0;
  end
`else
  assign rs_hit = 1'b0;
`endif

  // A new debounced fault makes any_flg true, so it always beats an ack.
  assign exit_ok = (ack_q || rs_hit) && !any_flg;

  always_comb begin
    st_nxt  = st_q;
    src_nxt = src_q | rise;
    mot_all = &src_nxt[N_MOT-1:0];
    unique case (st_q)
      S_IDLE: begin
        if (|rise)
          st_nxt = S_FAULT;
        else if (idle_cnt == IDLE_MAX)
          st_nxt = S_RUN;
      end
      S_RUN: begin
        if (sens_rise)
          st_nxt = S_FAULT;
        else if (mot_rise)
          st_nxt = S_DEG;
      end
      S_DEG: begin
        if (sens_rise || mot_all)
          st_nxt = S_FAULT;
        else if (exit_ok)
          st_nxt = S_IDLE;
      end
      S_FAULT: begin
        if (exit_ok)
          st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
    if (st_nxt == S_IDLE && st_q != S_IDLE)
      src_nxt = '0;
  end

  // The first edge after reset only fills the input registers.
  always_comb begin
    idle_nxt = '0;
    if (st_q == S_IDLE && st_nxt == S_IDLE) begin
      if (in_vld && idle_cnt != IDLE_MAX)
        idle_nxt = idle_cnt + 1'b1;
      else
        idle_nxt = idle_cnt;
    end
  end

  always_comb begin
    blk_cnt_nxt = blk_cnt;
    blk_nxt     = blk_q;
    if (st_nxt == S_RUN || st_nxt == S_DEG) begin
      if (st_nxt != st_q) begin
        blk_cnt_nxt = '0;
        blk_nxt     = 1'b1;
      end else if (blk_cnt == BLK_LAST) begin
        blk_cnt_nxt = '0;
        blk_nxt     = ~blk_q;
      end else begin
        blk_cnt_nxt = blk_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    ena_nxt = '0;
    if (st_nxt == S_RUN)
      ena_nxt = '1;
    else if (st_nxt == S_DEG)
      ena_nxt = ~src_nxt[N_MOT-1:0];
    grn_nxt = (st_nxt == S_RUN) && blk_nxt;
    red_nxt = ((st_nxt == S_DEG) && blk_nxt) ||
              (st_nxt == S_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      raw_q    <= '0;
      ack_q    <= 1'b0;
      flg_q    <= '0;
      st_q     <= S_IDLE;
      src_q    <= '0;
      idle_cnt <= '0;
      in_vld   <= 1'b0;
      blk_cnt  <= '0;
      blk_q    <= 1'b0;
      ena_q    <= '0;
      grn_q    <= 1'b0;
      red_q    <= 1'b0;
      for (int i = 0; i < NCH; i++)
        deb_cnt[i] <= '0;
    end else begin
      raw_q    <= {~FAIL_SENSn, MOT_ERR};
      ack_q    <= FAULT_ACK;
      flg_q    <= flg_nxt;
      st_q     <= st_nxt;
      src_q    <= src_nxt;
      idle_cnt <= idle_nxt;
      in_vld   <= 1'b1;
      blk_cnt  <= blk_cnt_nxt;
      blk_q    <= blk_nxt;
      ena_q    <= ena_nxt;
      grn_q    <= grn_nxt;
      red_q    <= red_nxt;
      for (int i = 0; i < NCH; i++)
        deb_cnt[i] <= deb_nxt[i];
    end
  end

  assign MOT_ENA   = ena_q;
  assign LED_GREEN = grn_q;
  assign LED_RED   = red_q;
  assign FAULT_SRC = src_q;
  assign STATE     = st_q;

endmodule
